serial_parity_checker: RTL

Receives a serial bitstream framed as DATA_BITS data bits plus one trailing parity bit. Deserialises the data and accumulates parity with a running XOR. Reports each completed frame with a one-cycle strobe, a pass/fail flag and a saturating error count. Sits directly downstream of the team's XOR gate primitive: it is the sequential consumer that folds single-bit XOR results across a whole frame.

---
 rtl/serial_parity_checker_if.sv | 40 ++++
 rtl/serial_parity_checker.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_parity_checker_if.sv
// Bit-serial handshake and frame-report bundle for serial_parity_checker.
// The master side is the upstream bit source; the slave side is the checker itself.
interface serial_parity_checker_if #(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 bit_in;
  logic                 bit_valid;
  logic                 frame_start;
  logic                 bit_ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_ok;
  logic                 frame_valid;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_clr;

  modport master (
    output bit_in,
    output bit_valid,
    output frame_start,
    output err_clr,
    input  bit_ready,
    input  data_out,
    input  parity_ok,
    input  frame_valid,
    input  err_count
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  frame_start,
    input  err_clr,
    output bit_ready,
    output data_out,
    output parity_ok,
    output frame_valid,
    output err_count
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Deserialises DATA_BITS-bit frames with a trailing parity bit, folds parity with a
// running XOR, and reports each frame with a one-cycle strobe and a saturating error count.
module serial_parity_checker #(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8,
  parameter bit ODD       = 1'b0
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_parity_checker_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [CNT_W-1:0]     LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  logic [1:0]           state;
  logic [CNT_W-1:0]     count;
  logic                 acc;
  logic [DATA_BITS-1:0] shift;

  logic [DATA_BITS-1:0] data_q;
  logic                 parity_ok_q;
  logic                 frame_valid_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic bit_ready;
  logic accept;
  logic restart;
  logic parity_fail;
  logic frame_done;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    bit_ready   = 1'b0;
    parity_fail = 1'b0;
    frame_done  = 1'b0;
    if (state != S_REPORT) bit_ready = 1'b1;
    if (state == S_PARITY && accept && !bus.frame_start) begin
      frame_done  = 1'b1;
      parity_fail = acc ^ bus.bit_in ^ ODD;
    end
  end

  assign accept  = bus.bit_valid & bit_ready;
  // A start marker wins in every accepting state: it opens a new frame or aborts the current one.
  assign restart = accept & bus.frame_start;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      count         <= '0;
      acc           <= 1'b0;
      shift         <= '0;
      data_q        <= '0;
      parity_ok_q   <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (restart) begin
        shift <= {{(DATA_BITS-1){1'b0}}, bus.bit_in};
        acc   <= bus.bit_in;
        count <= CNT_W'(1);
        state <= S_DATA;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_DATA: begin
            if (accept) begin
              shift <= {shift[DATA_BITS-2:0], bus.bit_in};
              acc   <= acc ^ bus.bit_in;
              count <= count + CNT_W'(1);
              if (count == LAST_DATA) state <= S_PARITY;
            end
          end
          S_PARITY: begin
            if (frame_done) begin
              data_q        <= shift;
              parity_ok_q   <= ~parity_fail;
              frame_valid_q <= 1'b1;
              state         <= S_REPORT;
            end
          end
          S_REPORT: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Clear has priority over a coincident failed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (bus.err_clr) begin
      err_count_q <= '0;
    end else if (parity_fail && err_count_q != ERR_MAX) begin
      err_count_q <= err_count_q + ERR_CNT_W'(1);
    end
  end

  assign bus.bit_ready   = bit_ready;
  assign bus.data_out    = data_q;
  assign bus.parity_ok   = parity_ok_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err_count   = err_count_q;

endmodule
